cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_line_array.sv | 44 ++++
 rtl/cache_controller.sv | 147 ++++++++++++++
 tb/tb_cache_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared defaults and FSM state type for the direct-mapped write-through cache.
package cache_pkg;
  localparam int CACHE_INDEX_BITS = 3;
  localparam int CACHE_ADDR_BITS  = 5;
  localparam int CACHE_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_READ,
    MEM_WRITE,
    DONE
  } state_t;
endpackage

// File: rtl/cache_line_array.sv
// Tag/data/valid storage: one word per line, synchronous write, combinational read.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = CACHE_INDEX_BITS,
  parameter int TAG_BITS   = CACHE_ADDR_BITS - CACHE_INDEX_BITS,
  parameter int DATA_BITS  = CACHE_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [TAG_BITS-1:0]   wtag,
  input  logic [DATA_BITS-1:0]  wdata,
  output logic                  rvalid,
  output logic [TAG_BITS-1:0]   rtag,
  output logic [DATA_BITS-1:0]  rdata
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_reg;
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [DATA_BITS-1:0] data_mem [LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (we) begin
      valid_reg[idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      tag_mem[idx]  <= wtag;
      data_mem[idx] <= wdata;
    end
  end

  assign rvalid = valid_reg[idx];
  assign rtag   = tag_mem[idx];
  assign rdata  = data_mem[idx];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller between a CPU
// port and a handshaked memory port.
module cache_controller
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = CACHE_INDEX_BITS,
  parameter int ADDR_BITS  = CACHE_ADDR_BITS,
  parameter int DATA_BITS  = CACHE_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_wdata,
  output logic                 cpu_busy,
  output logic                 cpu_done,
  output logic                 cpu_hit,
  output logic [DATA_BITS-1:0] cpu_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_ack
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] addr_reg;
  logic                 we_reg;
  logic [DATA_BITS-1:0] wdata_reg;
  logic                 hit_reg;
  logic                 lookup_hit_reg;
  logic [DATA_BITS-1:0] rdata_reg;

  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [DATA_BITS-1:0]  line_data;
  logic                  lookup_hit;
  logic                  arr_we;
  logic [DATA_BITS-1:0]  arr_wdata;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;

  assign idx        = addr_reg[INDEX_BITS-1:0];
  assign tag        = addr_reg[ADDR_BITS-1:INDEX_BITS];
  assign lookup_hit = line_valid && (line_tag == tag);

  cache_line_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_lines (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .idx   (idx),
    .wtag  (tag),
    .wdata (arr_wdata),
    .rvalid(line_valid),
    .rtag  (line_tag),
    .rdata (line_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      hit_reg        <= 1'b0;
      lookup_hit_reg <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cpu_req) begin
        addr_reg  <= cpu_addr;
        we_reg    <= cpu_we;
        wdata_reg <= cpu_wdata;
      end
      // Result registers change only on the edge entering DONE so they hold between completions.
      if (state_reg == LOOKUP) begin
        lookup_hit_reg <= lookup_hit;
        if (!we_reg && lookup_hit) begin
          hit_reg   <= 1'b1;
          rdata_reg <= line_data;
        end
      end
      if (state_reg == MEM_READ && mem_ack) begin
        hit_reg   <= 1'b0;
        rdata_reg <= mem_rdata;
      end
      if (state_reg == MEM_WRITE && mem_ack) begin
        hit_reg <= lookup_hit_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    arr_we     = 1'b0;
    arr_wdata  = wdata_reg;
    cpu_busy   = (state_reg != IDLE);
    cpu_done   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_req) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (we_reg) begin
          state_next = MEM_WRITE;
          arr_we     = lookup_hit;
        end else if (lookup_hit) begin
          state_next = DONE;
        end else begin
          state_next = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_next = DONE;
          arr_we     = 1'b1;
          arr_wdata  = mem_rdata;
        end
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_next = DONE;
      end
      DONE: begin
        cpu_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_hit   = hit_reg;
  assign cpu_rdata = rdata_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: scoreboard of expected CPU results plus a
// fixed-latency memory responder that logs every memory transaction.
module tb_cache_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_busy, cpu_done, cpu_hit;
  logic [7:0] cpu_rdata;
  logic       mem_req, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       we;
    logic       hit;
    logic [7:0] rdata;
    string      name;
  } exp_t;
  exp_t exp_q[$];

  // Memory responds from a fixed table; writes are logged but do not alter it.
  logic [7:0] rom [32];
  int         mem_delay = 3;
  int         wait_cnt  = 0;
  int         mem_rd_cnt = 0;
  int         mem_wr_cnt = 0;
  logic [4:0] last_mem_addr;
  logic [7:0] last_mem_wdata;
  int         done_cnt = 0;

  cache_controller dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_busy (cpu_busy),
    .cpu_done (cpu_done),
    .cpu_hit  (cpu_hit),
    .cpu_rdata(cpu_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt == mem_delay) begin
        mem_ack        = 1'b1;
        mem_rdata      = rom[mem_addr];
        last_mem_addr  = mem_addr;
        last_mem_wdata = mem_wdata;
        if (mem_we) mem_wr_cnt++;
        else        mem_rd_cnt++;
        $display("MEM %s addr=%0d data=0x%0h", mem_we ? "write" : "read ", mem_addr,
                 mem_we ? mem_wdata : rom[mem_addr]);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Scoreboard: every cpu_done pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cpu_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(cpu_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ":hit"}, 32'(cpu_hit), 32'(e.hit));
          if (!e.we) check({e.name, ":rdata"}, 32'(cpu_rdata), 32'(e.rdata));
          $display("DONE %s hit=%0d rdata=0x%0h", e.name, cpu_hit, cpu_rdata);
        end
      end
    end
  end

  // exp_lat counts cycles with the request cycle as cycle 0; 0 skips the latency check.
  task automatic do_req(input string name, input logic we, input logic [4:0] addr,
                        input logic [7:0] wd, input logic exp_hit, input logic [7:0] exp_rd,
                        input int exp_rds, input int exp_wrs, input int exp_lat);
    int rd0, wr0, cyc;
    bit seen;
    rd0 = mem_rd_cnt;
    wr0 = mem_wr_cnt;
    exp_q.push_back('{we: we, hit: exp_hit, rdata: exp_rd, name: name});
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'd0;
    check({name, ":busy"}, 32'(cpu_busy), 32'd1);
    cyc  = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cpu_done) seen = 1;
    end
    check({name, ":done_seen"}, 32'(seen), 32'd1);
    if (exp_lat > 0) check({name, ":latency"}, 32'(cyc), 32'(exp_lat));
    check({name, ":mem_reads"}, 32'(mem_rd_cnt - rd0), 32'(exp_rds));
    check({name, ":mem_writes"}, 32'(mem_wr_cnt - wr0), 32'(exp_wrs));
    if (exp_rds + exp_wrs > 0) check({name, ":mem_addr"}, 32'(last_mem_addr), 32'(addr));
    if (exp_wrs > 0) check({name, ":mem_wdata"}, 32'(last_mem_wdata), 32'(wd));
    @(posedge clk);
    #1;
    check({name, ":done_pulse"}, 32'(cpu_done), 32'd0);
    check({name, ":hit_hold"}, 32'(cpu_hit), 32'(exp_hit));
    check({name, ":busy_idle"}, 32'(cpu_busy), 32'd0);
  endtask

  initial begin
    int rd0;
    bit seen;
    for (int i = 0; i < 32; i++) rom[i] = 8'(i) ^ 8'h40;
    rom[1]  = 8'hA5;
    rom[9]  = 8'h11;
    rom[17] = 8'h5A;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", 32'(cpu_busy), 32'd0);
    check("rst:done", 32'(cpu_done), 32'd0);
    check("rst:hit", 32'(cpu_hit), 32'd0);
    check("rst:rdata", 32'(cpu_rdata), 32'd0);
    check("rst:mem_req", 32'(mem_req), 32'd0);
    check("rst:mem_we", 32'(mem_we), 32'd0);
    check("rst:mem_addr", 32'(mem_addr), 32'd0);
    check("rst:mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_req("rd1_miss",     1'b0, 5'd1, 8'h00, 1'b0, 8'hA5, 1, 0, 0);
    do_req("rd1_hit",      1'b0, 5'd1, 8'h00, 1'b1, 8'hA5, 0, 0, 2);
    do_req("wr1_hit",      1'b1, 5'd1, 8'h3C, 1'b1, 8'h00, 0, 1, 0);
    do_req("rd1_after_wr", 1'b0, 5'd1, 8'h00, 1'b1, 8'h3C, 0, 0, 2);
    do_req("wr9_miss",     1'b1, 5'd9, 8'h77, 1'b0, 8'h00, 0, 1, 0);
    do_req("rd1_untouched",1'b0, 5'd1, 8'h00, 1'b1, 8'h3C, 0, 0, 2);
    do_req("rd9_evict",    1'b0, 5'd9, 8'h00, 1'b0, 8'h11, 1, 0, 0);
    do_req("rd1_evicted",  1'b0, 5'd1, 8'h00, 1'b0, 8'hA5, 1, 0, 0);

    // Abort a read miss with reset while memory is still waiting.
    rd0 = mem_rd_cnt;
    cpu_req = 1'b1; cpu_addr = 5'd17;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_addr = 5'd0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (mem_req) seen = 1;
    end
    check("abort:mem_req_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    check("abort:mem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("abort:mem_req_drop", 32'(mem_req), 32'd0);
    check("abort:busy", 32'(cpu_busy), 32'd0);
    check("abort:hit", 32'(cpu_hit), 32'd0);
    check("abort:rdata", 32'(cpu_rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort:no_mem_read", 32'(mem_rd_cnt - rd0), 32'd0);
    check("abort:done_count", 32'(done_cnt), 32'd8);

    do_req("rd1_after_rst", 1'b0, 5'd1, 8'h00, 1'b0, 8'hA5, 1, 0, 0);

    check("end:queue_empty", 32'(exp_q.size()), 32'd0);
    check("end:done_count", 32'(done_cnt), 32'd9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
